// File: rtl/tran_scheduler.sv
// -----------------------------------------------------------------------------
// tran_scheduler
//   Round-robin frame scheduler that shares one byte transmitter among N
//   requesters. An idle scheduler grants the first eligible requester at or
//   after the round-robin pointer. It then raises tx_start for one lead cycle
//   and pops len_w bytes from the winner's show-ahead source. Each popped byte
//   goes out as a paced tx_byte strobe. After the final strobe it closes the
//   envelope, pulses done, and idles for GAP_CYC cycles.
//
// Parameters
//   N         number of requesters (2..8)
//   BYTE_CYC  cycles between successive byte pops/strobes (>=1)
//   GAP_CYC   idle cycles with tx_start low after a frame (>=0)
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   req       per-requester frame request (level, sampled only when idle)
//   len       per-requester frame length, slice i = len[8i+7:8i]; 0 = ineligible
//   rd_data   per-requester show-ahead byte, slice i = rd_data[8i+7:8i]
//   rd_en     pop strobe to the granted requester (decoded from state)
//   gnt       one-hot grant, high from LEAD through TAIL
//   done      one-cycle pulse on the winner's bit when its frame completes
//   tx_start  frame envelope to the transmitter
//   tx_byte   one-cycle byte-valid strobe
//   tx_data   byte qualified by tx_byte; holds between strobes
//   busy      high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module tran_scheduler #(
  parameter int N        = 4,
  parameter int BYTE_CYC = 1,
  parameter int GAP_CYC  = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] len,
  input  logic [8*N-1:0] rd_data,
  output logic [N-1:0]   rd_en,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic           tx_start,
  output logic           tx_byte,
  output logic [7:0]     tx_data,
  output logic           busy
);

  localparam int IW = $clog2(N);
  localparam int CW = (BYTE_CYC > 1) ? $clog2(BYTE_CYC) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CW-1:0] BYTE_LAST = CW'(BYTE_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [2:0] {IDLE, LEAD, SEND, TAIL, GAP} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] w;
  logic [7:0]    rem;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap_cnt;

  logic [N-1:0]  w_oh;
  logic          pop;
  logic [N-1:0]  eligible;
  logic          any_elig;
  logic [IW-1:0] pick;

  assign w_oh = {{(N-1){1'b0}}, 1'b1} << w;
  // A byte is popped on the first cycle of every BYTE_CYC-long slot.
  assign pop  = (state == SEND) && (cnt == '0);

  // Round-robin search: first eligible index at or after ptr, with wrap.
  // NOTE: every variable assigned in always_comb gets a default up front so
  // that no path leaves it unassigned and no latch is inferred.
  always_comb begin
    any_elig = 1'b0;
    pick     = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = req[i] && (len[8*i +: 8] != 8'd0);
    end
    for (int off = 0; off < N; off++) begin
      int idx;
      idx = (int'(ptr) + off) % N;
      if (!any_elig && eligible[idx]) begin
        any_elig = 1'b1;
        pick     = IW'(idx);
      end
    end
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (any_elig) state_nxt = LEAD;
      LEAD: state_nxt = SEND;
      SEND: if (pop && rem == 8'd1) state_nxt = TAIL;
      TAIL: state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
      GAP:  if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; these clear as soon as reset forces IDLE.
  always_comb begin
    rd_en    = '0;
    gnt      = '0;
    tx_start = 1'b0;
    busy     = (state != IDLE);
    unique case (state)
      LEAD, TAIL: begin
        gnt      = w_oh;
        tx_start = 1'b1;
      end
      SEND: begin
        gnt      = w_oh;
        tx_start = 1'b1;
        if (pop) rd_en = w_oh;
      end
      default: ;
    endcase
  end

  // Datapath: winner latch, byte countdown, pacing, gap timing, tx outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr     <= '0;
      w       <= '0;
      rem     <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
      done    <= '0;
      tx_byte <= 1'b0;
      tx_data <= '0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (any_elig) begin
            w   <= pick;
            rem <= len[8*pick +: 8];
            cnt <= '0;
          end
        end
        SEND: begin
          if (pop) begin
            tx_data <= rd_data[8*w +: 8];
            tx_byte <= 1'b1;
            rem     <= rem - 8'd1;
          end else begin
            tx_byte <= 1'b0;
          end
          cnt <= (cnt == BYTE_LAST) ? '0 : cnt + 1'b1;
        end
        TAIL: begin
          tx_byte <= 1'b0;
          done    <= w_oh;
          ptr     <= (w == IW'(N - 1)) ? '0 : w + 1'b1;
          gap_cnt <= '0;
        end
        GAP:     gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tran_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tran_scheduler
//   Self-checking bench for tran_scheduler. Instance A: N=4, BYTE_CYC=1,
//   GAP_CYC=1. Instance B: N=4, BYTE_CYC=3, GAP_CYC=0. Each requester is
//   backed by a show-ahead source whose byte k is src_byte(i, k). A
//   cycle-by-cycle vector table covers the single-frame case. Hand-written
//   sequences, observed through a bounded watcher, cover the multi-frame and
//   reset corner cases.
// -----------------------------------------------------------------------------
module tb_tran_scheduler;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Instance A
  logic [N-1:0]   req_a, rd_en_a, gnt_a, done_a;
  logic [8*N-1:0] len_a, rd_a;
  logic           tx_start_a, tx_byte_a, busy_a;
  logic [7:0]     tx_data_a;

  // Instance B
  logic [N-1:0]   req_b, rd_en_b, gnt_b, done_b;
  logic [8*N-1:0] len_b, rd_b;
  logic           tx_start_b, tx_byte_b, busy_b;
  logic [7:0]     tx_data_b;

  tran_scheduler #(.N(N), .BYTE_CYC(1), .GAP_CYC(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .req(req_a), .len(len_a), .rd_data(rd_a),
    .rd_en(rd_en_a), .gnt(gnt_a), .done(done_a), .tx_start(tx_start_a),
    .tx_byte(tx_byte_a), .tx_data(tx_data_a), .busy(busy_a)
  );

  tran_scheduler #(.N(N), .BYTE_CYC(3), .GAP_CYC(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(req_b), .len(len_b), .rd_data(rd_b),
    .rd_en(rd_en_b), .gnt(gnt_b), .done(done_b), .tx_start(tx_start_b),
    .tx_byte(tx_byte_b), .tx_data(tx_data_b), .busy(busy_b)
  );

  // Source model: byte k of requester i.
  function automatic logic [7:0] src_byte(input int i, input int k);
    if (i == 2 && k == 0) return 8'hAA;
    if (i == 2 && k == 1) return 8'hF0;
    if (i == 2 && k == 2) return 8'h33;
    return 8'(i * 16 + k * 7 + 33);
  endfunction

  int pop_a [N];
  int pop_b [N];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        pop_a[i] <= 0;
        pop_b[i] <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rd_en_a[i]) pop_a[i] <= pop_a[i] + 1;
        if (rd_en_b[i]) pop_b[i] <= pop_b[i] + 1;
      end
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < N; i++) begin
      rd_a[8*i +: 8] = src_byte(i, pop_a[i]);
      rd_b[8*i +: 8] = src_byte(i, pop_b[i]);
    end
  end

  // Watcher view of the selected instance.
  logic           sel;
  logic [N-1:0]   m_gnt, m_done, m_rd_en;
  logic           m_tx_start, m_tx_byte;
  logic [7:0]     m_tx_data;
  always_comb begin
    m_gnt      = sel ? gnt_b      : gnt_a;
    m_done     = sel ? done_b     : done_a;
    m_rd_en    = sel ? rd_en_b    : rd_en_a;
    m_tx_start = sel ? tx_start_b : tx_start_a;
    m_tx_byte  = sel ? tx_byte_b  : tx_byte_a;
    m_tx_data  = sel ? tx_data_b  : tx_data_a;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Watcher results
  int g_q[$];    // requester index at each gnt rising edge
  int d_q[$];    // requester index of each done pulse
  int s_q[$];    // strobes counted in each completed frame
  int low_q[$];  // tx_start-low cycles between consecutive frames
  int space_bad, lead_bad, data_bad, orphan_bad;

  task automatic watch(input int nframes, input int spacing, input int budget);
    int frames = 0, cyc = 0, strobes = 0, last_strobe = -1, low = 0, w;
    int exp_k [N];
    logic in_gap = 1'b0;
    logic prev_ts;
    logic [N-1:0] prev_gnt, prev_rd;
    logic [N-1:0] one = 1;
    g_q.delete(); d_q.delete(); s_q.delete(); low_q.delete();
    space_bad = 0; lead_bad = 0; data_bad = 0; orphan_bad = 0;
    for (int i = 0; i < N; i++) exp_k[i] = 0;
    prev_ts = m_tx_start; prev_gnt = m_gnt; prev_rd = m_rd_en;
    while (frames < nframes && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (m_gnt != '0 && prev_gnt == '0) g_q.push_back(onehot_idx(m_gnt));
      if (m_tx_byte) begin
        w = onehot_idx(m_gnt);
        if (!m_tx_start || w < 0) orphan_bad++;
        else begin
          if (last_strobe >= 0 && cyc - last_strobe != spacing) space_bad++;
          if (prev_rd != (one << w)) lead_bad++;
          if (m_tx_data !== src_byte(w, exp_k[w])) data_bad++;
          exp_k[w]++;
        end
        last_strobe = cyc;
        strobes++;
      end
      if (m_done != '0) begin
        d_q.push_back(onehot_idx(m_done));
        s_q.push_back(strobes);
        strobes = 0;
        last_strobe = -1;
        frames++;
      end
      if (!m_tx_start && prev_ts) begin
        in_gap = 1'b1;
        low = 1;
      end else if (!m_tx_start && in_gap) begin
        low++;
      end else if (m_tx_start && !prev_ts && in_gap) begin
        low_q.push_back(low);
        in_gap = 1'b0;
      end
      prev_ts = m_tx_start; prev_gnt = m_gnt; prev_rd = m_rd_en;
    end
    check("watch_frames_in_budget", frames, nframes);
  endtask

  // Compare a queue against n expected values packed one per nibble, element 0 lowest.
  task automatic check_q(input string name, input int got[$], input logic [31:0] exp_nib, input int n);
    check({name, "_count"}, got.size(), n);
    for (int i = 0; i < got.size() && i < n; i++)
      check($sformatf("%s[%0d]", name, i), got[i], {28'd0, exp_nib[4*i +: 4]});
  endtask

  task automatic check_clean(input string tag);
    check({tag, "_spacing"}, space_bad, 0);
    check({tag, "_rd_en_lead"}, lead_bad, 0);
    check({tag, "_data"}, data_bad, 0);
    check({tag, "_byte_outside_start"}, orphan_bad, 0);
  endtask

  task automatic do_reset();
    req_a = '0;
    req_b = '0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Single-frame table: req applied before an edge, outputs expected after it.
  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [N-1:0] rd_en;
    logic [N-1:0] done;
    logic         tx_start;
    logic         tx_byte;
    logic [7:0]   tx_data;
    logic         busy;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h00, 1'b1}; // LEAD
    vt[1] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, 8'h00, 1'b1}; // SEND, req dropped
    vt[2] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1, 8'hAA, 1'b1};
    vt[3] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1, 8'hF0, 1'b1};
    vt[4] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h33, 1'b1}; // TAIL
    vt[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 8'h33, 1'b1}; // GAP + done
    vt[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h33, 1'b0}; // IDLE
    vt[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h33, 1'b0};

    sel = 1'b0;
    req_a = '0; req_b = '0;
    len_a = '0; len_b = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt_a, 0);
    check("rst_done", done_a, 0);
    check("rst_tx_start", tx_start_a, 0);
    check("rst_tx_byte", tx_byte_a, 0);
    check("rst_tx_data", tx_data_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_rd_en", rd_en_a, 0);
    check("rst_b_busy", busy_b, 0);
    reset_n = 1'b1;

    // Single frame: req[2], len2=3, bytes AA F0 33.
    len_a = {8'd1, 8'd3, 8'd1, 8'd1};
    for (int i = 0; i < 8; i++) begin
      req_a = vt[i].req;
      @(posedge clk); #1;
      check($sformatf("single[%0d]_gnt", i), gnt_a, vt[i].gnt);
      check($sformatf("single[%0d]_rd_en", i), rd_en_a, vt[i].rd_en);
      check($sformatf("single[%0d]_done", i), done_a, vt[i].done);
      check($sformatf("single[%0d]_tx_start", i), tx_start_a, vt[i].tx_start);
      check($sformatf("single[%0d]_tx_byte", i), tx_byte_a, vt[i].tx_byte);
      check($sformatf("single[%0d]_tx_data", i), tx_data_a, vt[i].tx_data);
      check($sformatf("single[%0d]_busy", i), busy_a, vt[i].busy);
    end

    // Round robin between requesters 0 and 1, two bytes each.
    do_reset();
    len_a = {8'd0, 8'd0, 8'd2, 8'd2};
    req_a = 4'b0011;
    watch(4, 1, 80);
    req_a = '0;
    check_q("rr_grant", g_q, 32'h1010, 4);
    check_q("rr_done", d_q, 32'h1010, 4);
    check_q("rr_strobes", s_q, 32'h2222, 4);
    check_q("rr_low_cycles", low_q, 32'h222, 3);
    check_clean("rr");

    // Pointer wrap: all four requesters, one byte each.
    do_reset();
    len_a = {8'd1, 8'd1, 8'd1, 8'd1};
    req_a = 4'b1111;
    watch(5, 1, 100);
    req_a = '0;
    check_q("wrap_grant", g_q, 32'h03210, 5);
    check_q("wrap_strobes", s_q, 32'h11111, 5);
    check_clean("wrap");

    // Zero length and pacing on instance B (BYTE_CYC=3, GAP_CYC=0).
    do_reset();
    sel = 1'b1;
    len_b = {8'd0, 8'd0, 8'd2, 8'd0};
    req_b = 4'b0011;
    watch(2, 3, 60);
    req_b = '0;
    check_q("zl_grant", g_q, 32'h11, 2);
    check_q("zl_done", d_q, 32'h11, 2);
    check_q("zl_strobes", s_q, 32'h22, 2);
    check_q("zl_low_cycles", low_q, 32'h1, 1);
    check_clean("zl");
    sel = 1'b0;

    // Reset in the middle of a 5-byte frame.
    do_reset();
    len_a = {8'd1, 8'd0, 8'd0, 8'd5};
    req_a = 4'b0001;
    begin
      int k = 0;
      while (!tx_byte_a && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
      check("rmf_first_strobe_seen", tx_byte_a, 1'b1);
    end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("rmf_gnt", gnt_a, 0);
    check("rmf_done", done_a, 0);
    check("rmf_tx_start", tx_start_a, 0);
    check("rmf_tx_byte", tx_byte_a, 0);
    check("rmf_tx_data", tx_data_a, 0);
    check("rmf_busy", busy_a, 0);
    check("rmf_rd_en", rd_en_a, 0);
    req_a = 4'b1001;
    @(posedge clk); #1;
    reset_n = 1'b1;
    watch(1, 1, 40);
    req_a = '0;
    check_q("rmf_grant", g_q, 32'h0, 1);
    check_q("rmf_strobes", s_q, 32'h5, 1);
    check_clean("rmf");

    // Request withdrawn after LEAD: frame still completes with len3=4 bytes.
    do_reset();
    len_a = {8'd4, 8'd0, 8'd0, 8'd0};
    req_a = 4'b1000;
    begin
      int k = 0;
      while (gnt_a == '0 && k < 10) begin
        @(posedge clk); #1;
        k++;
      end
      check("wd_grant", gnt_a, 4'b1000);
    end
    @(posedge clk); #1;
    req_a = '0;
    watch(1, 1, 30);
    check_q("wd_done", d_q, 32'h3, 1);
    check_q("wd_strobes", s_q, 32'h4, 1);
    check_clean("wd");
    repeat (4) @(posedge clk);
    #1;
    check("wd_idle_busy", busy_a, 0);
    check("wd_idle_gnt", gnt_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
